// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI-slave register controller with programmable mic clock divider
//
// Samples SPI pins in the CLK_MCO domain, decodes byte-framed read/write
// commands into a small register file and drives the audio front-end
// configuration outputs.
//
// Ports:
//   CLK_MCO    in   system clock, rising edge
//   RST        in   synchronous active-high reset
//   SPI_SCK    in   SPI clock (mode 0), asynchronous
//   SPI_SS     in   SPI select, active-low, asynchronous
//   SPI_SI     in   SPI data in, MSB first
//   SPI_SO     out  SPI data out, MSB first
//   SPI_SO_OE  out  pad enable for SPI_SO while a frame is selected
//   MIC_CLK    out  divided mic clock
//   ATT        out  attention line, CTRL[2]
//   mic_en     out  CTRL[0]
//   spk_en     out  CTRL[1]
`timescale 1ns/1ps
module spi_reg_ctrl #(
   parameter logic [7:0] ID_VALUE    = 8'hA5,
   parameter logic [7:0] MIC_DIV_RST = 8'd3
) (
   input  logic CLK_MCO,
   input  logic RST,
   input  logic SPI_SCK,
   input  logic SPI_SS,
   input  logic SPI_SI,
   output logic SPI_SO,
   output logic SPI_SO_OE,
   output logic MIC_CLK,
   output logic ATT,
   output logic mic_en,
   output logic spk_en
);

   typedef enum logic [1:0] {WAIT_SS, IDLE, CMD, DATA} state_t;

   state_t      state_q, state_d;

   logic        sck_s1_q, sck_s2_q, sck_s3_q;
   logic        ss_s1_q, ss_s2_q;
   logic        si_s1_q, si_s2_q;

   logic [2:0]  bit_cnt_q;
   logic [6:0]  rx_shift_q;
   logic        rw_q;
   logic [6:0]  addr_q;
   logic [7:0]  tx_shift_q;
   logic        load_pend_q;
   logic        oe_q;

   logic [7:0]  ctrl_q, div_q, scratch_q;
   logic [7:0]  mic_cnt_q;
   logic        mic_clk_q;

   logic        sck_rise, sck_fall;
   logic        in_frame, byte_done, wr_en;
   logic [7:0]  rx_byte;
   logic [7:0]  rd_data;

   // Synchronizers. SS resets to "selected" so that WAIT_SS cannot leave
   // before the real pin level has propagated: a frame that was already
   // running across reset must be seen to end before a new one is accepted.
   always_ff @(posedge CLK_MCO) begin
      if (RST) begin
         sck_s1_q <= 1'b0;
         sck_s2_q <= 1'b0;
         sck_s3_q <= 1'b0;
         ss_s1_q  <= 1'b0;
         ss_s2_q  <= 1'b0;
         si_s1_q  <= 1'b0;
         si_s2_q  <= 1'b0;
      end else begin
         sck_s1_q <= SPI_SCK;
         sck_s2_q <= sck_s1_q;
         sck_s3_q <= sck_s2_q;
         ss_s1_q  <= SPI_SS;
         ss_s2_q  <= ss_s1_q;
         si_s1_q  <= SPI_SI;
         si_s2_q  <= si_s1_q;
      end
   end

   assign sck_rise  = sck_s2_q & ~sck_s3_q;
   assign sck_fall  = ~sck_s2_q & sck_s3_q;
   assign in_frame  = ((state_q == CMD) || (state_q == DATA)) && !ss_s2_q;
   assign rx_byte   = {rx_shift_q, si_s2_q};
   assign byte_done = in_frame && sck_rise && (bit_cnt_q == 3'd7);
   assign wr_en     = byte_done && (state_q == DATA) && !rw_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_SS: if (ss_s2_q) state_d = IDLE;
         IDLE:    if (!ss_s2_q) state_d = CMD;
         CMD: begin
            if (ss_s2_q)        state_d = IDLE;
            else if (byte_done) state_d = DATA;
         end
         DATA:    if (ss_s2_q) state_d = IDLE;
         default: state_d = WAIT_SS;
      endcase
   end

   always_ff @(posedge CLK_MCO) begin
      if (RST) state_q <= WAIT_SS;
      else     state_q <= state_d;
   end

   always_comb begin
      rd_data = 8'h00;
      case (addr_q)
         7'h00:   rd_data = ID_VALUE;
         7'h01:   rd_data = ctrl_q;
         7'h02:   rd_data = div_q;
         7'h03:   rd_data = scratch_q;
         default: rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge CLK_MCO) begin
      if (RST) begin
         bit_cnt_q   <= 3'd0;
         rx_shift_q  <= 7'd0;
         rw_q        <= 1'b0;
         addr_q      <= 7'd0;
         tx_shift_q  <= 8'h00;
         load_pend_q <= 1'b0;
         oe_q        <= 1'b0;
         ctrl_q      <= 8'h00;
         div_q       <= MIC_DIV_RST;
         scratch_q   <= 8'h00;
      end else begin
         oe_q <= !ss_s2_q && (state_q != WAIT_SS);

         if (state_q == IDLE && !ss_s2_q) begin
            bit_cnt_q   <= 3'd0;
            tx_shift_q  <= 8'h00;
            load_pend_q <= 1'b0;
         end else if (in_frame) begin
            if (sck_rise) begin
               bit_cnt_q  <= bit_cnt_q + 3'd1;
               rx_shift_q <= rx_byte[6:0];
               if (bit_cnt_q == 3'd7) begin
                  // Next fall reloads tx_shift instead of shifting.
                  load_pend_q <= 1'b1;
                  if (state_q == CMD) begin
                     rw_q   <= rx_byte[7];
                     addr_q <= rx_byte[6:0];
                  end else begin
                     addr_q <= addr_q + 7'd1;
                  end
               end
            end else if (sck_fall) begin
               if (load_pend_q) begin
                  tx_shift_q  <= rw_q ? rd_data : 8'h00;
                  load_pend_q <= 1'b0;
               end else begin
                  tx_shift_q <= {tx_shift_q[6:0], 1'b0};
               end
            end
         end else begin
            // Deselect mid-byte: drop the partial byte.
            bit_cnt_q   <= 3'd0;
            load_pend_q <= 1'b0;
         end

         if (wr_en) begin
            case (addr_q)
               7'h01:   ctrl_q    <= rx_byte;
               7'h02:   div_q     <= rx_byte;
               7'h03:   scratch_q <= rx_byte;
               default: ;
            endcase
         end
      end
   end

   // Using >= rather than == lets a lowered divider take effect at once
   // instead of running the counter up to 255 first.
   always_ff @(posedge CLK_MCO) begin
      if (RST || !ctrl_q[0]) begin
         mic_cnt_q <= 8'd0;
         mic_clk_q <= 1'b0;
      end else if (mic_cnt_q >= div_q) begin
         mic_cnt_q <= 8'd0;
         mic_clk_q <= ~mic_clk_q;
      end else begin
         mic_cnt_q <= mic_cnt_q + 8'd1;
      end
   end

   assign SPI_SO    = tx_shift_q[7];
   assign SPI_SO_OE = oe_q;
   assign MIC_CLK   = mic_clk_q;
   assign mic_en    = ctrl_q[0];
   assign spk_en    = ctrl_q[1];
   assign ATT       = ctrl_q[2];

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - scoreboard testbench for spi_reg_ctrl
`timescale 1ns/1ps
module tb_spi_reg_ctrl;

   logic clk = 1'b0;
   logic rst, sck, ss, si;
   logic so, oe, mic_clk, att, mic_en, spk_en;

   always #5 clk = ~clk;

   spi_reg_ctrl #(.ID_VALUE(8'hA5), .MIC_DIV_RST(8'd3)) dut (
      .CLK_MCO   (clk),
      .RST       (rst),
      .SPI_SCK   (sck),
      .SPI_SS    (ss),
      .SPI_SI    (si),
      .SPI_SO    (so),
      .SPI_SO_OE (oe),
      .MIC_CLK   (mic_clk),
      .ATT       (att),
      .mic_en    (mic_en),
      .spk_en    (spk_en)
   );

   logic [7:0] exp_q[$];
   string      nm_q[$];
   logic       mon_valid;
   logic [7:0] mon_data;
   logic       done;
   int         n_cmp, n_err;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_push(input string nm, input logic [7:0] v);
      exp_q.push_back(v);
      nm_q.push_back(nm);
   endtask

   task automatic present(input logic [7:0] a);
      mon_data  = a;
      mon_valid = 1'b1;
      @(negedge clk);
      mon_valid = 1'b0;
   endtask

   task automatic check(input string nm, input logic [7:0] a, input logic [7:0] e);
      expect_push(nm, e);
      present(a);
   endtask

   task automatic spi_bit(input logic b, output logic r);
      si = b;
      cyc(8);
      r = so;
      sck = 1'b1;
      cyc(8);
      sck = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] t, output logic [7:0] r);
      for (int i = 7; i >= 0; i--) spi_bit(t[i], r[i]);
   endtask

   task automatic wait_toggle(output int n);
      logic p;
      p = mic_clk;
      n = 0;
      while (mic_clk == p && n < 64) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Last rise of the byte is placed 3 cycles after a MIC_CLK toggle, so the
   // write lands with the divider counter at 6; the three gaps to the next
   // toggles are measured while SCK is high.
   task automatic spi_byte_sync(input logic [7:0] t, output int c1, output int c2, output int c3);
      logic r;
      int   dummy;
      for (int i = 7; i >= 1; i--) spi_bit(t[i], r);
      si = t[0];
      cyc(8);
      wait_toggle(dummy);
      cyc(3);
      sck = 1'b1;
      wait_toggle(c1);
      wait_toggle(c2);
      wait_toggle(c3);
      cyc(2);
      sck = 1'b0;
   endtask

   task automatic frame_begin();
      ss = 1'b0;
      cyc(8);
   endtask

   task automatic frame_end();
      cyc(8);
      ss = 1'b1;
      cyc(10);
   endtask

   task automatic wr(input logic [6:0] a, input logic [7:0] d);
      logic [7:0] r;
      frame_begin();
      spi_byte({1'b0, a}, r);
      spi_byte(d, r);
      frame_end();
   endtask

   task automatic rd1(input string nm, input logic [6:0] a, input logic [7:0] e);
      logic [7:0] r;
      expect_push(nm, e);
      frame_begin();
      spi_byte({1'b1, a}, r);
      spi_byte(8'h00, r);
      frame_end();
      present(r);
   endtask

   task automatic rd2(input string nm, input logic [6:0] a, input logic [7:0] e0, input logic [7:0] e1);
      logic [7:0] r, r0, r1;
      expect_push({nm, "_0"}, e0);
      expect_push({nm, "_1"}, e1);
      frame_begin();
      spi_byte({1'b1, a}, r);
      spi_byte(8'h00, r0);
      spi_byte(8'h00, r1);
      frame_end();
      present(r0);
      present(r1);
   endtask

   // Monitor: pops the oldest expectation whenever an observation is presented.
   initial begin
      logic [7:0] e;
      string      nm;
      n_cmp = 0;
      n_err = 0;
      while (!done) begin
         @(posedge clk);
         if (mon_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_output actual=%02h required=none", mon_data);
            end else begin
               e  = exp_q.pop_front();
               nm = nm_q.pop_front();
               if (mon_data !== e) begin
                  n_err++;
                  $display("FAIL %s actual=%02h required=%02h", nm, mon_data, e);
               end
            end
         end
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] r0, r1, cmd_so;
      logic       oe_mid, oe_after;
      int         n, c1, c2, c3, highs;

      rst = 1'b1; sck = 1'b0; ss = 1'b1; si = 1'b0;
      mon_valid = 1'b0; mon_data = 8'h00; done = 1'b0;
      cyc(4);
      rst = 1'b0;
      cyc(6);

      check("reset_outputs", {2'b00, so, oe, mic_clk, att, mic_en, spk_en}, 8'h00);
      rd1("reset_mic_div", 7'h02, 8'h03);
      rd1("reset_ctrl", 7'h01, 8'h00);

      // ID read with SO and OE observation
      expect_push("id_cmd_so", 8'h00);
      expect_push("id_value", 8'hA5);
      expect_push("oe_in_frame", 8'h01);
      expect_push("oe_after_frame", 8'h00);
      frame_begin();
      spi_byte(8'h80, cmd_so);
      oe_mid = oe;
      spi_byte(8'h00, r1);
      frame_end();
      oe_after = oe;
      present(cmd_so);
      present(r1);
      present({7'd0, oe_mid});
      present({7'd0, oe_after});

      // Burst write CTRL=0x03, MIC_DIV=0x00
      frame_begin();
      spi_byte(8'h01, r0);
      spi_byte(8'h03, r0);
      spi_byte(8'h00, r0);
      frame_end();
      check("ctrl_outputs", {5'd0, att, spk_en, mic_en}, 8'h03);
      wait_toggle(n);
      wait_toggle(n);
      check("mic_half_period_div0_a", 8'(n), 8'd1);
      wait_toggle(n);
      check("mic_half_period_div0_b", 8'(n), 8'd1);
      rd2("burst_read", 7'h01, 8'h03, 8'h00);

      // Divider 9, then lowered to 2 mid-count
      wr(7'h01, 8'h00);
      check("mic_clk_disabled", {7'd0, mic_clk}, 8'h00);
      wr(7'h02, 8'h09);
      wr(7'h01, 8'h01);
      wait_toggle(n);
      wait_toggle(n);
      check("mic_half_period_div9", 8'(n), 8'd10);
      frame_begin();
      spi_byte(8'h02, r0);
      spi_byte_sync(8'h02, c1, c2, c3);
      frame_end();
      check("div_lower_first_toggle", 8'(c1), 8'd4);
      check("div2_half_period_a", 8'(c2), 8'd3);
      check("div2_half_period_b", 8'(c3), 8'd3);
      wr(7'h01, 8'h00);
      highs = 0;
      for (int i = 0; i < 8; i++) begin
         if (mic_clk) highs++;
         cyc(1);
      end
      check("mic_clk_off_after_clear", 8'(highs), 8'd0);
      check("mic_en_cleared", {7'd0, mic_en}, 8'h00);

      // CTRL upper bits and ATT
      wr(7'h01, 8'hF8);
      rd1("ctrl_upper_bits", 7'h01, 8'hF8);
      wr(7'h01, 8'h04);
      check("att_only", {5'd0, att, spk_en, mic_en}, 8'h04);
      wr(7'h01, 8'h00);

      // Abort mid-byte
      frame_begin();
      spi_byte(8'h03, r0);
      for (int i = 0; i < 4; i++) spi_bit(1'b1, r0[0]);
      frame_end();
      rd1("abort_scratch", 7'h03, 8'h00);
      wr(7'h03, 8'h5A);
      rd1("scratch_after_abort", 7'h03, 8'h5A);

      // Reset during a frame, SS held low while clocking continues
      frame_begin();
      for (int i = 0; i < 3; i++) spi_bit(1'b0, r0[0]);
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      spi_byte(8'h03, r0);
      spi_byte(8'h07, r0);
      frame_end();
      rd1("rst_mid_scratch", 7'h03, 8'h00);
      rd1("rst_mid_mic_div", 7'h02, 8'h03);
      rd1("rst_mid_ctrl", 7'h01, 8'h00);

      wr(7'h05, 8'h77);
      rd1("unmapped_addr", 7'h05, 8'h00);
      rd2("wrap_read", 7'h7F, 8'h00, 8'hA5);

      cyc(3);
      done = 1'b1;
   end

endmodule
